// File: rtl/uart_cmd_parser.sv
// Byte-stream frame parser: HDR, CMD, P_H, P_L, CHK. Good frames are presented on a
// valid/ready output; checksum, timeout and overrun errors are pulsed and counted.
module uart_cmd_parser #(
  parameter int         TIMEOUT_CYC = 43400,
  parameter logic [7:0] HDR_BYTE    = 8'hAA
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic [7:0]  cmd,
  output logic [15:0] param,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_PH   = 3'd2;
  localparam logic [2:0] S_PL   = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_CHK  = 2'd1;
  localparam logic [1:0] E_TMO  = 2'd2;
  localparam logic [1:0] E_OVR  = 2'd3;

  logic [2:0]    state_q, state_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    cmd_sh_q, cmd_sh_d;
  logic [7:0]    ph_q, ph_d;
  logic [7:0]    pl_q, pl_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [15:0]   param_q, param_d;
  logic          vld_q, vld_d;
  logic          pulse_q, pulse_d;
  logic [1:0]    code_q, code_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    err;

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    cmd_sh_d = cmd_sh_q;
    ph_d     = ph_q;
    pl_d     = pl_q;
    cmd_d    = cmd_q;
    param_d  = param_q;
    vld_d    = vld_q & ~cmd_ready;
    pulse_d  = 1'b0;
    code_d   = code_q;
    cnt_d    = cnt_q;
    err      = E_NONE;
    tmo_d    = (rx_vld || state_q == S_IDLE) ? '0 : tmo_q + 1'b1;

    if (rx_vld) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == HDR_BYTE) begin
            state_d = S_CMD;
            sum_d   = 8'd0;
          end
        end
        S_CMD: begin
          cmd_sh_d = rx_data;
          sum_d    = sum_q + rx_data;
          state_d  = S_PH;
        end
        S_PH: begin
          ph_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = S_PL;
        end
        S_PL: begin
          pl_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = S_CHK;
        end
        S_CHK: begin
          state_d = S_IDLE;
          if (rx_data == sum_q) begin
            // A pending frame being consumed this cycle frees the slot for the new one.
            if (!vld_q || cmd_ready) begin
              cmd_d   = cmd_sh_q;
              param_d = {ph_q, pl_q};
              vld_d   = 1'b1;
            end else begin
              err = E_OVR;
            end
          end else begin
            err = E_CHK;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
      state_d = S_IDLE;
      tmo_d   = '0;
      err     = E_TMO;
    end

    if (err != E_NONE) begin
      pulse_d = 1'b1;
      code_d  = err;
      cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q <= S_IDLE;
      sum_q   <= 8'd0;
      tmo_q   <= '0;
      cmd_q   <= 8'd0;
      param_q <= 16'd0;
      vld_q   <= 1'b0;
      pulse_q <= 1'b0;
      code_q  <= E_NONE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      cmd_q   <= cmd_d;
      param_q <= param_d;
      vld_q   <= vld_d;
      pulse_q <= pulse_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shadow bytes are always written before they are read, so they carry no reset.
  always_ff @(posedge sclk) begin
    cmd_sh_q <= cmd_sh_d;
    ph_q     <= ph_d;
    pl_q     <= pl_d;
  end

  assign cmd       = cmd_q;
  assign param     = param_q;
  assign cmd_valid = vld_q;
  assign err_pulse = pulse_q;
  assign err_code  = code_q;
  assign err_cnt   = cnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames with literal expectations, then random
// byte traffic compared every cycle against a frame-level reference model.
module tb_uart_cmd_parser;

  localparam int         T   = 40;
  localparam logic [7:0] HDR = 8'hAA;

  logic        sclk = 1'b0;
  logic        s_rst;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic [7:0]  cmd;
  logic [15:0] param;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [7:0]  err_cnt;
  logic        busy;

  uart_cmd_parser #(.TIMEOUT_CYC(T), .HDR_BYTE(HDR)) dut (
    .sclk(sclk), .s_rst(s_rst), .rx_data(rx_data), .rx_vld(rx_vld),
    .cmd(cmd), .param(param), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .err_pulse(err_pulse), .err_code(err_code), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit rnd_ready = 1'b0;

  // Reference model: frame position, collected bytes, cycles since last byte.
  int         cyc = 0;
  int         last_byte = 0;
  int         pos = 0;
  logic [7:0] fb [3];
  logic [7:0] m_cmd = 8'd0;
  logic [15:0] m_param = 16'd0;
  logic       m_valid = 1'b0;
  logic       m_pulse = 1'b0;
  logic [1:0] m_code = 2'd0;
  int         m_cnt = 0;

  always @(posedge sclk) begin
    int e;
    int s;
    logic nv;
    cyc = cyc + 1;
    if (s_rst) begin
      pos = 0; m_cmd = 8'd0; m_param = 16'd0; m_valid = 1'b0;
      m_pulse = 1'b0; m_code = 2'd0; m_cnt = 0;
    end else begin
      e  = 0;
      nv = m_valid && !cmd_ready;
      if (rx_vld) begin
        last_byte = cyc;
        if (pos == 0) begin
          if (rx_data == HDR) pos = 1;
        end else if (pos < 4) begin
          fb[pos-1] = rx_data;
          pos = pos + 1;
        end else begin
          pos = 0;
          s = (int'(fb[0]) + int'(fb[1]) + int'(fb[2])) % 256;
          if (int'(rx_data) == s) begin
            if (!m_valid || cmd_ready) begin
              m_cmd = fb[0]; m_param = {fb[1], fb[2]}; nv = 1'b1;
            end else e = 3;
          end else e = 1;
        end
      end else if (pos != 0 && cyc - last_byte == T) begin
        pos = 0;
        e = 2;
      end
      m_pulse = (e != 0);
      if (e != 0) begin
        m_code = 2'(e);
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
      m_valid = nv;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sclk) begin
    if (cmp_en) begin
      chk("cmd", 32'(cmd), 32'(m_cmd));
      chk("param", 32'(param), 32'(m_param));
      chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
      chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
      chk("err_code", 32'(err_code), 32'(m_code));
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
      chk("busy", 32'(busy), 32'(pos != 0));
    end
  end

  task automatic tick();
    if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
    @(negedge sclk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
    @(negedge sclk);
    rx_vld  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] ph,
                            input logic [7:0] pl, input logic [7:0] ck);
    send_byte(HDR); send_byte(c); send_byte(ph); send_byte(pl); send_byte(ck);
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    tick(); tick();
    s_rst = 1'b0;
  endtask

  initial begin
    s_rst = 1'b1; rx_data = 8'd0; rx_vld = 1'b0; cmd_ready = 1'b1;
    repeat (3) @(negedge sclk);
    s_rst = 1'b0;
    cmp_en = 1'b1;

    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_valid", 32'(cmd_valid), 32'h0);
    chk("rst_cnt", 32'(err_cnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Good frame, consumer ready.
    send_frame(8'h10, 8'h01, 8'hF4, 8'h05);
    chk("good_valid", 32'(cmd_valid), 32'h1);
    chk("good_cmd", 32'(cmd), 32'h10);
    chk("good_param", 32'(param), 32'h01F4);
    chk("model_param", 32'(m_param), 32'h01F4);
    tick();
    chk("good_valid_drop", 32'(cmd_valid), 32'h0);
    chk("good_cnt", 32'(err_cnt), 32'h0);

    // Bad checksum.
    send_frame(8'h10, 8'h01, 8'hF4, 8'h06);
    chk("bad_pulse", 32'(err_pulse), 32'h1);
    chk("bad_code", 32'(err_code), 32'h1);
    chk("bad_cnt", 32'(err_cnt), 32'h1);
    chk("bad_valid", 32'(cmd_valid), 32'h0);
    tick();
    chk("bad_pulse_once", 32'(err_pulse), 32'h0);

    // Timeout after two bytes.
    send_byte(HDR); send_byte(8'h10);
    chk("tmo_busy_before", 32'(busy), 32'h1);
    repeat (T - 1) tick();
    chk("tmo_not_yet", 32'(err_pulse), 32'h0);
    tick();
    chk("tmo_code", 32'(err_code), 32'h2);
    chk("tmo_pulse", 32'(err_pulse), 32'h1);
    chk("tmo_busy", 32'(busy), 32'h0);
    chk("model_code", 32'(m_code), 32'h2);
    send_frame(8'h33, 8'h12, 8'h34, 8'h79);
    chk("tmo_after_cmd", 32'(cmd), 32'h33);
    chk("tmo_after_param", 32'(param), 32'h1234);
    tick();

    // Overrun.
    cmd_ready = 1'b0;
    send_frame(8'h01, 8'h00, 8'h00, 8'h01);
    chk("ovr_first", 32'(cmd), 32'h01);
    send_frame(8'h02, 8'h00, 8'h00, 8'h02);
    chk("ovr_keep", 32'(cmd), 32'h01);
    chk("ovr_code", 32'(err_code), 32'h3);
    chk("ovr_valid", 32'(cmd_valid), 32'h1);
    cmd_ready = 1'b1;
    tick();
    chk("ovr_clear", 32'(cmd_valid), 32'h0);

    // Garbage then frame.
    send_byte(8'h00); send_byte(8'h55); send_byte(8'hFF);
    chk("garbage_busy", 32'(busy), 32'h0);
    send_frame(8'h20, 8'h00, 8'h00, 8'h20);
    chk("garb_cmd", 32'(cmd), 32'h20);
    chk("garb_param", 32'(param), 32'h0);
    chk("garb_cnt", 32'(err_cnt), 32'h3);
    tick();

    // Reset mid-frame with a frame pending.
    cmd_ready = 1'b0;
    send_frame(8'h44, 8'h00, 8'h01, 8'h45);
    send_byte(HDR); send_byte(8'h10);
    do_reset();
    chk("mrst_valid", 32'(cmd_valid), 32'h0);
    chk("mrst_cmd", 32'(cmd), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_cnt", 32'(err_cnt), 32'h0);
    chk("mrst_pulse", 32'(err_pulse), 32'h0);
    cmd_ready = 1'b1;
    send_frame(8'h10, 8'h01, 8'hF4, 8'h05);
    chk("mrst_good_cmd", 32'(cmd), 32'h10);
    chk("mrst_good_param", 32'(param), 32'h01F4);
    tick();

    // Random traffic.
    rnd_ready = 1'b1;
    for (int it = 0; it < 400; it++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 65) begin
        logic [7:0] c, ph, pl, ck;
        c = 8'($urandom); ph = 8'($urandom); pl = 8'($urandom);
        ck = c + ph + pl;
        if ($urandom_range(0, 4) == 0) ck = ck + 8'($urandom_range(1, 255));
        send_byte(HDR);
        foreach (fb[k]) begin end
        send_byte(c);
        if ($urandom_range(0, 9) == 0) repeat ($urandom_range(T - 2, T + 3)) tick();
        send_byte(ph);
        repeat ($urandom_range(0, 2)) tick();
        send_byte(pl);
        send_byte(ck);
      end else if (sel < 90) begin
        send_byte(8'($urandom));
      end else if (sel < 95) begin
        repeat ($urandom_range(1, 4)) tick();
      end else begin
        send_byte(HDR);
        repeat ($urandom_range(0, 2)) send_byte(8'($urandom));
        do_reset();
      end
    end
    rnd_ready = 1'b0;
    cmd_ready = 1'b1;
    repeat (T + 5) tick();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
